ysyx_24100006_idu: RTL and testbench

//  Decode stage directly downstream of instruction fetch: accepts {pc, instruction} beats on a valid/ready

---
 rtl/ysyx_24100006_idu_pkg.sv | 70 +++++++
 rtl/ysyx_24100006_immgen.sv | 33 +++
 rtl/ysyx_24100006_idu.sv | 233 +++++++++++++++++++++++
 tb/tb_ysyx_24100006_idu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_idu_pkg.sv
// ysyx_24100006_idu_pkg
//   Shared decode definitions for the IDU: RV32I opcodes, ALU operation
//   encodings, jump encodings and the immediate-format selector.
package ysyx_24100006_idu_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int ALU_OP_W_DEF = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_JAL  = 2'd1;
  localparam logic [1:0] JMP_JALR = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  function automatic imm_sel_e imm_sel_of(input logic [6:0] opc);
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: imm_sel_of = IMM_I;
      OPC_STORE:                                 imm_sel_of = IMM_S;
      OPC_BRANCH:                                imm_sel_of = IMM_B;
      OPC_LUI, OPC_AUIPC:                        imm_sel_of = IMM_U;
      OPC_JAL:                                   imm_sel_of = IMM_J;
      default:                                   imm_sel_of = IMM_NONE;
    endcase
  endfunction

  // Base register/immediate ALU op for a funct3 (funct7 variants handled by caller).
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_of_f3 = ALU_ADD;
      3'b001:  alu_of_f3 = ALU_SLL;
      3'b010:  alu_of_f3 = ALU_SLT;
      3'b011:  alu_of_f3 = ALU_SLTU;
      3'b100:  alu_of_f3 = ALU_XOR;
      3'b101:  alu_of_f3 = ALU_SRL;
      3'b110:  alu_of_f3 = ALU_OR;
      default: alu_of_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24100006_immgen.sv
// ysyx_24100006_immgen
//   Combinational immediate generator. Picks the I/S/B/U/J format from the
//   opcode and sign-extends from inst[31] to XLEN; R-type and unknown
//   opcodes yield 0.
// Ports
//   inst  in   32    instruction word
//   imm   out  XLEN  sign-extended immediate
module ysyx_24100006_immgen
  import ysyx_24100006_idu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_sel_of(inst[6:0]))
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/ysyx_24100006_idu.sv
// ysyx_24100006_idu
//   RV32I decode stage (plus ecall/ebreak) with a one-entry output register.
//   Input side: in_valid/in_ready carrying {in_pc, in_inst} from IFU.
//   Output side: out_valid/out_ready carrying the decoded bundle to EXU.
//   flush discards both the held beat and any incoming beat.
// Configuration
//   RV32E_EN  defined: 16-register RV32E, any used index with bit4 set is illegal.
// Ports
//   clk, reset (sync, active-high), flush
//   in_valid, in_ready, in_pc, in_inst
//   out_valid, out_ready, out_pc, out_rs1/rs2/rd, out_imm, out_alu_op,
//   out_src2_imm, out_src1_pc, out_rf_wen, out_mem_ren, out_mem_wen,
//   out_mem_size, out_branch, out_jump, out_ecall, out_ebreak, out_illegal
module ysyx_24100006_idu
  import ysyx_24100006_idu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ALU_OP_W = ALU_OP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_imm,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_src2_imm,
  output logic                out_src1_pc,
  output logic                out_rf_wen,
  output logic                out_mem_ren,
  output logic                out_mem_wen,
  output logic [2:0]          out_mem_size,
  output logic                out_branch,
  output logic [1:0]          out_jump,
  output logic                out_ecall,
  output logic                out_ebreak,
  output logic                out_illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  logic [XLEN-1:0] d_imm;

  ysyx_24100006_immgen #(.XLEN(XLEN)) u_immgen (
    .inst (in_inst),
    .imm  (d_imm)
  );

  logic       use_rs1, use_rs2, use_rd;
  logic [3:0] d_alu;
  logic       d_src2_imm, d_src1_pc, d_mem_ren, d_mem_wen, d_branch;
  logic       d_ecall, d_ebreak, d_bad;
  logic [2:0] d_mem_size;
  logic [1:0] d_jump;
  logic       bad_opc;

  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    d_alu      = ALU_ADD;
    d_src2_imm = 1'b0;
    d_src1_pc  = 1'b0;
    d_mem_ren  = 1'b0;
    d_mem_wen  = 1'b0;
    d_mem_size = 3'b000;
    d_branch   = 1'b0;
    d_jump     = JMP_NONE;
    d_ecall    = 1'b0;
    d_ebreak   = 1'b0;
    bad_opc    = 1'b0;
    case (opc)
      OPC_LUI: begin
        use_rd     = 1'b1;
        d_src2_imm = 1'b1;
        d_alu      = ALU_LUI;
      end
      OPC_AUIPC: begin
        use_rd     = 1'b1;
        d_src1_pc  = 1'b1;
        d_src2_imm = 1'b1;
      end
      OPC_JAL: begin
        use_rd     = 1'b1;
        d_src1_pc  = 1'b1;
        d_src2_imm = 1'b1;
        d_jump     = JMP_JAL;
      end
      OPC_JALR: begin
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        d_src2_imm = 1'b1;
        d_jump     = JMP_JALR;
        bad_opc    = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        d_branch   = 1'b1;
        d_mem_size = f3;
        bad_opc    = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        d_src2_imm = 1'b1;
        d_mem_ren  = 1'b1;
        d_mem_size = f3;
        bad_opc    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        d_src2_imm = 1'b1;
        d_mem_wen  = 1'b1;
        d_mem_size = f3;
        bad_opc    = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        d_src2_imm = 1'b1;
        d_alu      = alu_of_f3(f3);
        if (f3 == 3'b001) begin
          bad_opc = (f7 != 7'b0);
        end else if (f3 == 3'b101) begin
          // inst[30] picks srai over srli; every other funct7 bit must be 0
          d_alu   = in_inst[30] ? ALU_SRA : ALU_SRL;
          bad_opc = ({f7[6], f7[4:0]} != 6'b0);
        end
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        d_alu   = alu_of_f3(f3);
        if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      d_alu   = ALU_SUB;
          else if (f3 == 3'b101) d_alu   = ALU_SRA;
          else                   bad_opc = 1'b1;
        end else if (f7 != 7'b0) begin
          bad_opc = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (in_inst == 32'h0000_0073)      d_ecall  = 1'b1;
        else if (in_inst == 32'h0010_0073) d_ebreak = 1'b1;
        else                               bad_opc  = 1'b1;
      end
      default: bad_opc = 1'b1;
    endcase
  end

`ifdef RV32E_EN
  logic bad_reg;
  assign bad_reg = (use_rs1 & in_inst[19]) | (use_rs2 & in_inst[24]) | (use_rd & in_inst[11]);
`else
  logic bad_reg;
  assign bad_reg = 1'b0;
`endif

  assign d_bad = bad_opc | bad_reg | (in_inst[1:0] != 2'b11);

  logic [4:0] d_rs1, d_rs2, d_rd;
  assign d_rs1 = use_rs1 ? in_inst[19:15] : 5'd0;
  assign d_rs2 = use_rs2 ? in_inst[24:20] : 5'd0;
  assign d_rd  = use_rd  ? in_inst[11:7]  : 5'd0;

  logic accept;
  assign in_ready = flush | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_imm      <= '0;
      out_alu_op   <= '0;
      out_src2_imm <= 1'b0;
      out_src1_pc  <= 1'b0;
      out_rf_wen   <= 1'b0;
      out_mem_ren  <= 1'b0;
      out_mem_wen  <= 1'b0;
      out_mem_size <= '0;
      out_branch   <= 1'b0;
      out_jump     <= '0;
      out_ecall    <= 1'b0;
      out_ebreak   <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1      <= d_rs1;
      out_rs2      <= d_rs2;
      out_rd       <= d_rd;
      out_imm      <= d_imm;
      out_alu_op   <= ALU_OP_W'(d_alu);
      out_src2_imm <= d_src2_imm;
      out_src1_pc  <= d_src1_pc;
      // an illegal beat still issues, but with every side effect suppressed
      out_rf_wen   <= use_rd & (d_rd != 5'd0) & ~d_bad;
      out_mem_ren  <= d_mem_ren & ~d_bad;
      out_mem_wen  <= d_mem_wen & ~d_bad;
      out_mem_size <= d_mem_size;
      out_branch   <= d_branch & ~d_bad;
      out_jump     <= d_bad ? JMP_NONE : d_jump;
      out_ecall    <= d_ecall;
      out_ebreak   <= d_ebreak;
      out_illegal  <= d_bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_idu.sv
module tb_ysyx_24100006_idu;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_inst;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic        out_src2_imm, out_src1_pc, out_rf_wen, out_mem_ren, out_mem_wen;
  logic [2:0]  out_mem_size;
  logic        out_branch;
  logic [1:0]  out_jump;
  logic        out_ecall, out_ebreak, out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_24100006_idu dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_src2_imm(out_src2_imm), .out_src1_pc(out_src1_pc),
    .out_rf_wen(out_rf_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
    .out_mem_size(out_mem_size), .out_branch(out_branch), .out_jump(out_jump),
    .out_ecall(out_ecall), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
    step(); step();
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++;
    if ({out_pc, out_imm, out_rs1, out_rs2, out_rd, out_alu_op, out_rf_wen, out_jump,
         out_illegal, out_mem_size, out_src2_imm, out_src1_pc} !== '0) begin
      bad++; $display("FAIL reset_fields got pc=%h imm=%h rd=%0d exp all 0", out_pc, out_imm, out_rd);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h0000_0100; in_inst = 32'hFFF1_0093;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rs1, out_rs2, out_rd, out_imm, out_src2_imm, out_rf_wen, out_alu_op, out_illegal, out_pc}
        !== {1'b1, 5'd2, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0000_0100}) begin
      bad++;
      $display("FAIL addi got v=%b rs1=%0d rs2=%0d rd=%0d imm=%h s2i=%b wen=%b alu=%0d ill=%b pc=%h exp v=1 rs1=2 rs2=0 rd=1 imm=ffffffff s2i=1 wen=1 alu=0 ill=0 pc=00000100",
               out_valid, out_rs1, out_rs2, out_rd, out_imm, out_src2_imm, out_rf_wen, out_alu_op, out_illegal, out_pc);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_jal();
    in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0080_00EF;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_jump, out_imm, out_src1_pc, out_src2_imm, out_rd, out_rf_wen, out_rs1, out_pc}
        !== {1'b1, 2'd1, 32'h0000_0008, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 32'h8000_0000}) begin
      bad++;
      $display("FAIL jal got v=%b jump=%0d imm=%h pc1=%b s2i=%b rd=%0d wen=%b rs1=%0d pc=%h exp v=1 jump=1 imm=00000008 pc1=1 s2i=1 rd=1 wen=1 rs1=0 pc=80000000",
               out_valid, out_jump, out_imm, out_src1_pc, out_src2_imm, out_rd, out_rf_wen, out_rs1, out_pc);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0200; in_inst = 32'h0020_81B3; // add x3,x1,x2
    step();
    in_pc = 32'h0000_0204; in_inst = 32'h4073_02B3; // sub x5,x6,x7
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({in_ready, out_valid, out_rd, out_rs1, out_rs2, out_alu_op, out_pc}
          !== {1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 4'd0, 32'h0000_0200}) begin
        bad++;
        $display("FAIL hold_%0d got rdy=%b v=%b rd=%0d rs1=%0d rs2=%0d alu=%0d pc=%h exp rdy=0 v=1 rd=3 rs1=1 rs2=2 alu=0 pc=00000200",
                 i, in_ready, out_valid, out_rd, out_rs1, out_rs2, out_alu_op, out_pc);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rd, out_rs1, out_rs2, out_alu_op, out_pc}
        !== {1'b1, 5'd5, 5'd6, 5'd7, 4'd1, 32'h0000_0204}) begin
      bad++;
      $display("FAIL second_beat got v=%b rd=%0d rs1=%0d rs2=%0d alu=%0d pc=%h exp v=1 rd=5 rs1=6 rs2=7 alu=1 pc=00000204",
               out_valid, out_rd, out_rs1, out_rs2, out_alu_op, out_pc);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0300; in_inst = 32'h0050_0393; // addi x7,x0,5
    step();
    flush = 1'b1; in_pc = 32'h0000_0304; in_inst = 32'h0090_0413; // addi x8,x0,9 (dropped)
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b11) begin
      bad++; $display("FAIL flush_ready got v=%b rdy=%b exp v=1 rdy=1", out_valid, in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_%0d got v=%b rd=%0d exp v=0", i, out_valid, out_rd); end
      step();
    end
    // flush together with reset
    in_valid = 1'b1; in_inst = 32'h0050_0393;
    step();
    in_valid = 1'b0; reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    total++;
    if ({out_valid, out_rd, out_imm} !== '0) begin
      bad++; $display("FAIL flush_reset got v=%b rd=%0d imm=%h exp all 0", out_valid, out_rd, out_imm);
    end
  endtask

  task automatic test_illegal_system();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h0000_0400; in_inst = 32'h0000_0000;
    step();
    in_inst = 32'h0010_0073;
    total++;
    if ({out_valid, out_illegal, out_rf_wen, out_mem_ren, out_mem_wen, out_branch, out_jump} !== 8'b1100_0000) begin
      bad++; $display("FAIL zero_inst got v=%b ill=%b wen=%b exp v=1 ill=1 wen=0", out_valid, out_illegal, out_rf_wen);
    end
    step();
    in_inst = 32'h0000_0073;
    total++;
    if ({out_valid, out_ebreak, out_ecall, out_illegal, out_rf_wen} !== 5'b11000) begin
      bad++; $display("FAIL ebreak got v=%b ebrk=%b ecall=%b ill=%b exp v=1 ebrk=1 ecall=0 ill=0", out_valid, out_ebreak, out_ecall, out_illegal);
    end
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_ecall, out_ebreak, out_illegal} !== 4'b1100) begin
      bad++; $display("FAIL ecall got v=%b ecall=%b ebrk=%b ill=%b exp v=1 ecall=1 ebrk=0 ill=0", out_valid, out_ecall, out_ebreak, out_illegal);
    end
    step();
  endtask

  task automatic test_rv32e();
    in_valid = 1'b1; in_inst = 32'h0020_8833; // add x16,x1,x2
    step();
    in_valid = 1'b0;
    total++;
`ifdef RV32E_EN
    if ({out_valid, out_illegal, out_rf_wen} !== 3'b110) begin
      bad++; $display("FAIL rv32e_x16 got v=%b ill=%b wen=%b exp v=1 ill=1 wen=0", out_valid, out_illegal, out_rf_wen);
    end
`else
    if ({out_valid, out_illegal, out_rf_wen, out_rd} !== {3'b101, 5'd16}) begin
      bad++; $display("FAIL rv32i_x16 got v=%b ill=%b wen=%b rd=%0d exp v=1 ill=0 wen=1 rd=16", out_valid, out_illegal, out_rf_wen, out_rd);
    end
`endif
    step();
  endtask

  // Full-throughput stream: one beat per cycle, each checked the cycle after it is offered.
  task automatic test_back_to_back();
    logic [31:0] insts [7] = '{32'h0000_0013, 32'h0080_006F, 32'h0210_9093, 32'h4030_D093,
                                32'h0020_A423, 32'hFE20_8EE3, 32'h1234_52B7};
    logic [4:0]  e_rd  [7] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd5};
    logic [31:0] e_imm [7] = '{32'h0, 32'h8, 32'h21, 32'h403, 32'h8, 32'hFFFF_FFFC, 32'h1234_5000};
    logic        e_wen [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        e_ill [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  e_alu [7] = '{4'd0, 4'd0, 4'd2, 4'd7, 4'd0, 4'd0, 4'd10};
    logic [1:0]  e_jmp [7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [2:0]  e_msz [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0};
    logic        e_mwe [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        e_br  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_pc = 32'h0000_1000 + 32'(i * 4); in_inst = insts[i];
      step();
      total++;
      if ({out_valid, in_ready, out_rd, out_imm, out_rf_wen, out_illegal, out_alu_op, out_jump,
           out_mem_size, out_mem_wen, out_branch, out_pc}
          !== {1'b1, 1'b1, e_rd[i], e_imm[i], e_wen[i], e_ill[i], e_alu[i], e_jmp[i],
               e_msz[i], e_mwe[i], e_br[i], 32'h0000_1000 + 32'(i * 4)}) begin
        bad++;
        $display("FAIL b2b_%0d got v=%b rdy=%b rd=%0d imm=%h wen=%b ill=%b alu=%0d jmp=%0d msz=%0d mwe=%b br=%b pc=%h exp rd=%0d imm=%h wen=%b ill=%b alu=%0d jmp=%0d msz=%0d mwe=%b br=%b",
                 i, out_valid, in_ready, out_rd, out_imm, out_rf_wen, out_illegal, out_alu_op, out_jump,
                 out_mem_size, out_mem_wen, out_branch, out_pc,
                 e_rd[i], e_imm[i], e_wen[i], e_ill[i], e_alu[i], e_jmp[i], e_msz[i], e_mwe[i], e_br[i]);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jal();
    test_backpressure();
    test_flush();
    test_illegal_system();
    test_rv32e();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
